// File: rtl/switch_dest_lookup.sv
// switch_dest_lookup: resolves the first-beat DMAC against a forwarding table and
// tags every beat of the frame with one latched egress bitmap (forward, flood or drop).
module switch_dest_lookup #(
    parameter int AXIS_DATA_WIDTH  = 64,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_ID_ENABLE   = 1,
    parameter int AXIS_ID_WIDTH    = 8,
    parameter int AXIS_USER_ENABLE = 1,
    parameter int AXIS_USER_WIDTH  = 17,
    parameter int RADIX            = 4,
    parameter int PORT_INDEX       = 0,
    parameter int TABLE_SIZE       = 16,
    localparam int AW              = $clog2(TABLE_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_ID_WIDTH-1:0]   s_axis_tid,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_ID_WIDTH-1:0]   m_axis_tid,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,
    output logic [RADIX-1:0]           m_axis_tdest,
    input  logic                       cfg_wr_en,
    input  logic [AW-1:0]              cfg_wr_addr,
    input  logic [47:0]                cfg_wr_mac,
    input  logic [RADIX-1:0]           cfg_wr_mask,
    input  logic                       cfg_wr_valid,
    output logic                       stat_flood,
    output logic                       stat_drop
);
    localparam logic [RADIX-1:0] SELF = {{(RADIX-1){1'b0}}, 1'b1} << PORT_INDEX;

    logic [TABLE_SIZE-1:0]      r_tbl_valid;
    logic [47:0]                r_tbl_mac  [TABLE_SIZE];
    logic [RADIX-1:0]           r_tbl_mask [TABLE_SIZE];

    logic                       r_sof;
    logic [RADIX-1:0]           r_dest;
    logic                       r_a_valid;
    logic                       r_a_first;
    logic [AXIS_DATA_WIDTH-1:0] r_a_data;
    logic [AXIS_KEEP_WIDTH-1:0] r_a_keep;
    logic                       r_a_last;
    logic [AXIS_ID_WIDTH-1:0]   r_a_id;
    logic [AXIS_USER_WIDTH-1:0] r_a_user;
    logic                       r_b_valid;
    logic [AXIS_DATA_WIDTH-1:0] r_b_data;
    logic [AXIS_KEEP_WIDTH-1:0] r_b_keep;
    logic                       r_b_last;
    logic [AXIS_ID_WIDTH-1:0]   r_b_id;
    logic [AXIS_USER_WIDTH-1:0] r_b_user;
    logic [RADIX-1:0]           r_b_dest;

    logic [47:0]                w_dmac;
    logic                       w_hit;
    logic [RADIX-1:0]           w_hit_mask;
    logic                       w_flood;
    logic [RADIX-1:0]           w_lookup;
    logic [RADIX-1:0]           w_dest;
    logic                       w_a_drop;
    logic                       w_a_adv;
    logic                       w_a_leave;
    logic                       w_s_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tbl_valid <= '0;
        else if (cfg_wr_en)
            r_tbl_valid[cfg_wr_addr] <= cfg_wr_valid;
    end

    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            r_tbl_mac[cfg_wr_addr]  <= cfg_wr_mac;
            r_tbl_mask[cfg_wr_addr] <= cfg_wr_mask;
        end
    end

    assign w_dmac = r_a_data[47:0];

    // Scan high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_mask = '0;
        for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
            if (r_tbl_valid[i] && r_tbl_mac[i] == w_dmac) begin
                w_hit      = 1'b1;
                w_hit_mask = r_tbl_mask[i];
            end
        end
    end

    assign w_flood   = w_dmac[0] || !w_hit;
    assign w_lookup  = (w_flood ? {RADIX{1'b1}} : w_hit_mask) & ~SELF;
    assign w_dest    = r_a_first ? w_lookup : r_dest;
    assign w_a_drop  = r_a_valid && (w_dest == '0);
    assign w_a_adv   = !r_b_valid || m_axis_tready;
    assign w_a_leave = r_a_valid && (w_a_adv || w_a_drop);
    assign w_s_fire  = s_axis_tvalid && s_axis_tready;

    assign s_axis_tready = rst_n && (!r_a_valid || w_a_adv || w_a_drop);
    assign stat_flood    = w_a_leave && r_a_first && w_flood;
    assign stat_drop     = w_a_leave && r_a_first && (w_dest == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sof     <= 1'b1;
            r_dest    <= '0;
            r_a_valid <= 1'b0;
            r_a_first <= 1'b0;
            r_a_data  <= '0;
            r_a_keep  <= '0;
            r_a_last  <= 1'b0;
            r_a_id    <= '0;
            r_a_user  <= '0;
        end else begin
            if (w_s_fire) begin
                r_a_valid <= 1'b1;
                r_a_first <= r_sof;
                r_a_data  <= s_axis_tdata;
                r_a_keep  <= s_axis_tkeep;
                r_a_last  <= s_axis_tlast;
                r_a_id    <= s_axis_tid;
                r_a_user  <= s_axis_tuser;
                r_sof     <= s_axis_tlast;
            end else if (w_a_leave) begin
                r_a_valid <= 1'b0;
            end
            if (w_a_leave && r_a_first)
                r_dest <= w_lookup;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
            r_b_keep  <= '0;
            r_b_last  <= 1'b0;
            r_b_id    <= '0;
            r_b_user  <= '0;
            r_b_dest  <= '0;
        end else if (w_a_adv) begin
            r_b_valid <= r_a_valid && !w_a_drop;
            if (r_a_valid && !w_a_drop) begin
                r_b_data <= r_a_data;
                r_b_keep <= r_a_keep;
                r_b_last <= r_a_last;
                r_b_id   <= r_a_id;
                r_b_user <= r_a_user;
                r_b_dest <= w_dest;
            end
        end
    end

    assign m_axis_tvalid = r_b_valid;
    assign m_axis_tdata  = r_b_data;
    assign m_axis_tkeep  = r_b_keep;
    assign m_axis_tlast  = r_b_last;
    assign m_axis_tid    = (AXIS_ID_ENABLE != 0) ? r_b_id : '0;
    assign m_axis_tuser  = (AXIS_USER_ENABLE != 0) ? r_b_user : '0;
    assign m_axis_tdest  = r_b_dest;
endmodule

// File: tb/tb_switch_dest_lookup.sv
// tb_switch_dest_lookup: directed checks of three instances (PORT_INDEX 0..2) sharing
// one stimulus; the instance under test is chosen by sel.
module tb_switch_dest_lookup;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [16:0] user;
        logic [3:0]  dest;
    } beat_t;

    localparam logic [47:0] MAC_HIT = 48'h0B00_0000_0002;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] UNK     = 48'h5544_3322_1102;
    localparam logic [47:0] MAC_X   = 48'h6655_4433_2202;
    localparam logic [47:0] MCAST   = 48'h0100_005E_0001;
    localparam logic [47:0] MAC_Y   = 48'h7766_5544_3302;
    localparam logic [47:0] MAC_Z   = 48'h1234_5678_9A02;
    localparam logic [47:0] M1      = 48'hA1A1_A1A1_A102;
    localparam logic [47:0] M3      = 48'hB3B3_B3B3_B302;
    localparam logic [47:0] M4      = 48'hC4C4_C4C4_C402;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tid = '0;
    logic [16:0] s_tuser = '0;
    logic        m_tready = 1'b1;
    logic        cfg_wr_en = 1'b0;
    logic [3:0]  cfg_wr_addr = '0;
    logic [47:0] cfg_wr_mac = '0;
    logic [3:0]  cfg_wr_mask = '0;
    logic        cfg_wr_valid = 1'b0;

    logic [2:0]  s_tready;
    logic [63:0] m_tdata [3];
    logic [7:0]  m_tkeep [3];
    logic [2:0]  m_tvalid;
    logic [2:0]  m_tlast;
    logic [7:0]  m_tid [3];
    logic [16:0] m_tuser [3];
    logic [3:0]  m_tdest [3];
    logic [2:0]  stat_flood;
    logic [2:0]  stat_drop;

    int    errors = 0;
    int    checks = 0;
    int    sel = 0;
    bit    bp_en = 1'b0;
    int    n_flood = 0;
    int    n_drop = 0;
    int    fid_n = 1;
    beat_t obs[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        switch_dest_lookup #(.PORT_INDEX(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
            .s_axis_tready(s_tready[g]), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
            .s_axis_tuser(s_tuser),
            .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]), .m_axis_tvalid(m_tvalid[g]),
            .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[g]), .m_axis_tid(m_tid[g]),
            .m_axis_tuser(m_tuser[g]), .m_axis_tdest(m_tdest[g]),
            .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_mac(cfg_wr_mac),
            .cfg_wr_mask(cfg_wr_mask), .cfg_wr_valid(cfg_wr_valid),
            .stat_flood(stat_flood[g]), .stat_drop(stat_drop[g])
        );
    end

    function automatic beat_t out_beat(input int k);
        return '{data: m_tdata[k], keep: m_tkeep[k], last: m_tlast[k], id: m_tid[k],
                 user: m_tuser[k], dest: m_tdest[k]};
    endfunction

    function automatic beat_t mk_beat(input logic [47:0] dmac, input int i, input int len,
                                      input int fid, input logic [3:0] dest);
        beat_t b;
        b.data = (i == 0) ? {16'(fid), dmac} : {16'(fid), 16'(i), 32'hBEEF_0000 + 32'(fid)};
        b.keep = (i == len - 1) ? 8'(8'hFF >> (fid % 8)) : 8'hFF;
        b.last = (i == len - 1);
        b.id   = 8'(fid);
        b.user = 17'(i * 3 + fid);
        b.dest = dest;
        return b;
    endfunction

    // Transfers complete at the next rising edge; mid-cycle everything is stable.
    always @(negedge clk) begin
        if (rst_n && m_tvalid[sel] && m_tready) obs.push_back(out_beat(sel));
        if (rst_n && stat_flood[sel]) n_flood++;
        if (rst_n && stat_drop[sel]) n_drop++;
    end

    always @(posedge clk) begin
        #1;
        m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic drive(input beat_t b);
        s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last;
        s_tid = b.id; s_tuser = b.user; s_tvalid = 1'b1;
    endtask

    task automatic send_beat(input beat_t b);
        bit rdy;
        int n;
        drive(b);
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_tready[sel];
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 1000);
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout got=ready_low exp=accept within 1000 cycles");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dmac, input int len, input logic [3:0] dest,
                              input bit drop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = mk_beat(dmac, i, len, fid_n, dest);
            if (!drop) exp_q.push_back(b);
            send_beat(b);
        end
        fid_n++;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [47:0] mac, input logic [3:0] mask);
        cfg_wr_addr = addr; cfg_wr_mac = mac; cfg_wr_mask = mask;
        cfg_wr_valid = 1'b1; cfg_wr_en = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; s_tvalid = 1'b0; cfg_wr_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete(); exp_q.delete(); n_flood = 0; n_drop = 0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (obs.size() < exp_q.size() && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_tvalid !== 3'b000) begin errors++; $display("FAIL reset_tvalid got=%b exp=000", m_tvalid); end
        checks++;
        if (out_beat(0) !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", out_beat(0)); end
        checks++;
        if (s_tready !== 3'b000) begin errors++; $display("FAIL reset_tready got=%b exp=000", s_tready); end
        checks++;
        if ({stat_flood, stat_drop} !== 6'b0) begin
            errors++; $display("FAIL reset_stats got=%b exp=000000", {stat_flood, stat_drop});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_tready !== 3'b111) begin errors++; $display("FAIL ready_after_reset got=%b exp=111", s_tready); end
    endtask

    task automatic test_hit;
        beat_t b[4];
        sel = 0;
        do_reset();
        cfg_write(3, MAC_HIT, 4'b0100);
        for (int i = 0; i < 4; i++) b[i] = mk_beat(MAC_HIT, i, 4, fid_n, 4'b0100);
        fid_n++;
        drive(b[0]);
        @(posedge clk);
        #1;
        checks++;
        if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL hit_latency got=valid_early exp=valid_low"); end
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(b[k + 1]);
            else s_tvalid = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (m_tvalid[0] !== 1'b1 || out_beat(0) !== b[k]) begin
                errors++;
                $display("FAIL hit_beat%0d got=%b/%h exp=1/%h", k, m_tvalid[0], out_beat(0), b[k]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (n_flood != 0 || n_drop != 0) begin
            errors++; $display("FAIL hit_stats got=%0d/%0d exp=0/0", n_flood, n_drop);
        end
    endtask

    task automatic test_flood;
        sel = 2;
        do_reset();
        send_frame(BCAST, 2, 4'b1011, 0);
        send_frame(UNK, 3, 4'b1011, 0);
        drain();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL flood_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL flood_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if (n_flood != 2 || n_drop != 0) begin
            errors++; $display("FAIL flood_stats got=%0d/%0d exp=2/0", n_flood, n_drop);
        end
    endtask

    task automatic test_hairpin;
        sel = 1;
        do_reset();
        cfg_write(5, MAC_X, 4'b0010);
        send_frame(MAC_X, 3, 4'b0000, 1);
        send_frame(MCAST, 2, 4'b1101, 0);
        drain();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL hairpin_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL hairpin_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if (n_drop != 1 || n_flood != 1) begin
            errors++; $display("FAIL hairpin_stats got=%0d/%0d exp=1/1", n_drop, n_flood);
        end
    endtask

    task automatic test_midframe;
        beat_t b;
        sel = 0;
        do_reset();
        cfg_write(0, MAC_Y, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            b = mk_beat(MAC_Y, i, 4, fid_n, 4'b1000);
            exp_q.push_back(b);
            if (i == 2) begin
                cfg_wr_addr = 0; cfg_wr_mac = MAC_Y; cfg_wr_mask = 4'b0100;
                cfg_wr_valid = 1'b1; cfg_wr_en = 1'b1;
            end
            send_beat(b);
            cfg_wr_en = 1'b0;
        end
        fid_n++;
        send_frame(MAC_Y, 2, 4'b0100, 0);
        drain();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL midwrite_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL midwrite_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_bp;
        int cls, len, e_flood, e_drop;
        sel = 0;
        do_reset();
        cfg_write(1, M1, 4'b0110);
        cfg_write(2, M3, 4'b1011);
        cfg_write(4, M4, 4'b0001);
        cfg_write(6, M1, 4'b1111);
        e_flood = 0; e_drop = 0;
        bp_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            cls = $urandom_range(0, 4);
            len = $urandom_range(1, 9);
            case (cls)
                0: send_frame(M1, len, 4'b0110, 0);
                1: begin send_frame(BCAST, len, 4'b1110, 0); e_flood++; end
                2: begin send_frame(UNK, len, 4'b1110, 0); e_flood++; end
                3: send_frame(M3, len, 4'b1010, 0);
                default: begin send_frame(M4, len, 4'b0000, 1); e_drop++; end
            endcase
        end
        drain();
        bp_en = 1'b0;
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if (n_flood != e_flood || n_drop != e_drop) begin
            errors++; $display("FAIL random_stats got=%0d/%0d exp=%0d/%0d", n_flood, n_drop, e_flood, e_drop);
        end
    endtask

    task automatic test_reset_mid;
        sel = 0;
        do_reset();
        cfg_write(7, MAC_Z, 4'b0100);
        send_beat(mk_beat(MAC_Z, 0, 5, fid_n, 4'b0100));
        send_beat(mk_beat(MAC_Z, 1, 5, fid_n, 4'b0100));
        drive(mk_beat(MAC_Z, 2, 5, fid_n, 4'b0100));
        fid_n++;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid[0] !== 1'b0 || out_beat(0) !== '0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%h exp=0/0", m_tvalid[0], out_beat(0));
        end
        checks++;
        if (s_tready[0] !== 1'b0) begin errors++; $display("FAIL midreset_tready got=%b exp=0", s_tready[0]); end
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete(); exp_q.delete(); n_flood = 0; n_drop = 0;
        send_frame(MAC_Z, 2, 4'b1110, 0);
        cfg_write(7, MAC_Z, 4'b0100);
        send_frame(MAC_Z, 3, 4'b0100, 0);
        drain();
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++; $display("FAIL midreset_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if (n_flood != 1 || n_drop != 0) begin
            errors++; $display("FAIL midreset_stats got=%0d/%0d exp=1/0", n_flood, n_drop);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_flood();
        test_hairpin();
        test_midframe();
        test_random_bp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
